i2c_slave: RTL and testbench
============================

I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 SHALL have parameter: SLAVE_ADDR, default 7'h42, 7-bit address the block responds to.
REQ-002 SHALL have port: clk  input  1  system clock; all logic on posedge clk.
REQ-003 SHALL have port: rst  input  1  reset; one clock, synchronous, active-high.
REQ-004 SHALL have port: i2c_scl  input  1  bus clock from master, asynchronous to clk.
REQ-005 SHALL have port: i2c_sda  inout  1  bus data; the block drives only 0 or high-impedance, never 1.
REQ-006 SHALL have port: rd_data  input  8  byte returned to master on read; sampled when loaded into the shifter.
REQ-007 SHALL have port: rd_req  output  1  one-clk pulse when rd_data has been consumed and the next byte is needed.
REQ-008 SHALL have port: wr_data  output  8  last byte written by master.
REQ-009 SHALL have port: wr_valid  output  1  one-clk pulse when wr_data is updated.
REQ-010 SHALL have port: busy  output  1  high from address match until STOP, repeated START or NACKed read end.

Function
REQ-011 SHALL pass i2c_scl and i2c_sda through 2-FF synchronizers plus one history register; edges and conditions are detected on synchronized values only.
REQ-012 SHALL detect START as synchronized SDA 1->0 while synchronized SCL is 1, and STOP as SDA 0->1 while SCL is 1.
REQ-013 SHALL sample SDA on detected SCL rising edge and change its SDA drive only on detected SCL falling edge.
REQ-014 SHALL implement states IDLE, ADDR, ADDR_ACK, WRITE_DATA, WRITE_ACK, READ_DATA, READ_ACK.
REQ-015 SHALL go from any state to ADDR on START (including repeated START), clearing the bit counter to 0.
REQ-016 SHALL go from any state to IDLE on STOP, release SDA, and deassert busy in the same clock.
REQ-017 In ADDR, SHALL shift in 8 bits MSB first (7 address + R/W); after the 8th rising edge, compare address bits with SLAVE_ADDR.
REQ-018 On mismatch, SHALL return to IDLE without driving SDA and ignore the bus until the next START.
REQ-019 On match, SHALL enter ADDR_ACK, assert busy, drive SDA low from the next SCL falling edge until the following SCL falling edge.
REQ-020 After ADDR_ACK with R/W=0, SHALL enter WRITE_DATA; with R/W=1, SHALL load rd_data into the shifter, pulse rd_req, and enter READ_DATA.
REQ-021 In WRITE_DATA, after the 8th sampled bit, SHALL update wr_data, pulse wr_valid for exactly one clk, and enter WRITE_ACK.
REQ-022 In WRITE_ACK, SHALL always ACK (drive SDA low for one SCL period, falling edge to falling edge), then return to WRITE_DATA for the next byte.
REQ-023 In READ_DATA, SHALL drive SDA low for bit value 0 and release for bit value 1, MSB first, each bit presented from SCL falling edge; after 8 bits, release SDA and enter READ_ACK.
REQ-024 In READ_ACK, SHALL sample master ACK on SCL rising edge: ACK (0) -> load rd_data, pulse rd_req, back to READ_DATA; NACK (1) -> IDLE, SDA released, busy low.
REQ-025 SHALL produce rd_req and wr_valid as single-clk pulses, never high in the same clk.
REQ-026 Bit counter SHALL be 3 bits, wrapping 7->0 at each byte boundary without leaking into the next byte.
REQ-027 START and STOP SHALL take priority over a simultaneously detected SCL edge.

Reset
REQ-028 On rst=1, SHALL at the next posedge clk enter IDLE, release SDA, set wr_data=8'h00, wr_valid=0, rd_req=0, busy=0, and clear synchronizers to 1.
REQ-029 Reset asserted mid-transfer SHALL release SDA within one clk and ignore the bus until a fresh START after reset is deasserted.

Verification
REQ-030 Write to 0x42 with bytes 0xA5, 0x3C, then STOP -> ACK on address and both bytes; wr_valid pulses twice with wr_data=0xA5 then 0x3C; busy low after STOP.
REQ-031 Read from 0x42 with rd_data=0x96, master ACK then NACK, rd_data=0x0F for second -> SDA bits 10010110 then 00001111; rd_req pulses twice; IDLE after NACK.
REQ-032 Address 0x43 write -> SDA never driven low; no wr_valid; busy stays 0.
REQ-033 Write 0x42 byte 0x11, then repeated START to read 0x42 with rd_data=0xC3 -> wr_valid with 0x11, then ACK and SDA bits 11000011.
REQ-034 rst pulsed during 4th bit of a read byte -> SDA released next clk, all outputs at reset values, next valid transaction completes normally.
REQ-035 STOP injected mid-byte of a write -> IDLE, no wr_valid, SDA released.

Source files
------------

// File: rtl/i2c_slave.sv
// i2c_slave: I2C target that ACKs its 7-bit address, hands written bytes out and fetches read bytes on request
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h42
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i2c_scl,
    inout  wire        i2c_sda,
    input  logic [7:0] rd_data,
    output logic       rd_req,
    output logic [7:0] wr_data,
    output logic       wr_valid,
    output logic       busy
);
    typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WRITE_DATA, WRITE_ACK, READ_DATA, READ_ACK} state_t;
    state_t state_q, state_d;
    logic [2:0] scl_q, sda_q;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] sr_q, sr_d, wr_data_q, wr_data_d;
    logic drv_q, drv_d, wr_valid_q, wr_valid_d, rd_req_q, rd_req_d;
    logic scl_rise, scl_fall, start_det, stop_det;
    assign scl_rise  = scl_q[1] & ~scl_q[2];
    assign scl_fall  = ~scl_q[1] & scl_q[2];
    assign start_det = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
    assign stop_det  = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];
    assign i2c_sda   = drv_q ? 1'b0 : 1'bz;
    // two-stage synchronizers with a history stage for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_q <= 3'b111;
            sda_q <= 3'b111;
        end else begin
            scl_q <= {scl_q[1:0], i2c_scl};
            sda_q <= {sda_q[1:0], i2c_sda};
        end
    end
    // state and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            sr_q       <= 8'h00;
            drv_q      <= 1'b0;
            wr_data_q  <= 8'h00;
            wr_valid_q <= 1'b0;
            rd_req_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sr_q       <= sr_d;
            drv_q      <= drv_d;
            wr_data_q  <= wr_data_d;
            wr_valid_q <= wr_valid_d;
            rd_req_q   <= rd_req_d;
        end
    end
    // next state; in the ACK states drv_q doubles as the "ACK already driven" phase flag
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sr_d       = sr_q;
        drv_d      = drv_q;
        wr_data_d  = wr_data_q;
        wr_valid_d = 1'b0;
        rd_req_d   = 1'b0;
        if (start_det) begin
            state_d = ADDR;
            cnt_d   = 3'd0;
            drv_d   = 1'b0;
        end else if (stop_det) begin
            state_d = IDLE;
            cnt_d   = 3'd0;
            drv_d   = 1'b0;
        end else begin
            case (state_q)
                ADDR: if (scl_rise) begin
                    sr_d  = {sr_q[6:0], sda_q[1]};
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) state_d = (sr_q[6:0] == SLAVE_ADDR) ? ADDR_ACK : IDLE;
                end
                ADDR_ACK: if (scl_fall) begin
                    drv_d = ~drv_q;
                    if (drv_q) begin
                        state_d = sr_q[0] ? READ_DATA : WRITE_DATA;
                        if (sr_q[0]) begin
                            sr_d     = rd_data;
                            rd_req_d = 1'b1;
                            drv_d    = ~rd_data[7];
                        end
                    end
                end
                WRITE_DATA: if (scl_rise) begin
                    sr_d  = {sr_q[6:0], sda_q[1]};
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        wr_data_d  = {sr_q[6:0], sda_q[1]};
                        wr_valid_d = 1'b1;
                        state_d    = WRITE_ACK;
                    end
                end
                WRITE_ACK: if (scl_fall) begin
                    drv_d = ~drv_q;
                    if (drv_q) state_d = WRITE_DATA;
                end
                READ_DATA: if (scl_rise) begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) state_d = READ_ACK;
                end else if (scl_fall) begin
                    drv_d = ~sr_q[~cnt_q];
                end
                READ_ACK: if (scl_fall) begin
                    drv_d = 1'b0;
                end else if (scl_rise) begin
                    state_d = sda_q[1] ? IDLE : READ_DATA;
                    if (!sda_q[1]) begin
                        sr_d     = rd_data;
                        rd_req_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
    // outputs
    always_comb begin
        busy     = (state_q != IDLE) && (state_q != ADDR);
        rd_req   = rd_req_q;
        wr_valid = wr_valid_q;
        wr_data  = wr_data_q;
    end
endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: bus-level master driving i2c_slave, table, random and corner-case transactions
module tb_i2c_slave;
    localparam int Q = 8;
    logic clk = 1'b0, rst = 1'b1, scl = 1'b1, m_sda = 1'b1;
    logic [7:0] rd_data = 8'h00;
    wire sda_bus;
    logic rd_req, wr_valid, busy;
    logic [7:0] wr_data;
    int tests = 0, fails = 0;
    logic [7:0] wv_log[$];
    int rdreq_cnt = 0, both_cnt = 0, slave_low_cnt = 0;

    typedef struct {
        logic [6:0]  addr;
        logic        rw;
        int          n;
        logic [31:0] data;
        logic        exp_aack;
        logic        exp_busy;
        int          exp_cnt;
        logic [31:0] exp_bytes;
    } vec_t;

    assign sda_bus = m_sda ? 1'bz : 1'b0;
    pullup (sda_bus);
    always #5 clk = ~clk;

    i2c_slave #(.SLAVE_ADDR(7'h42)) dut (
        .clk(clk), .rst(rst), .i2c_scl(scl), .i2c_sda(sda_bus),
        .rd_data(rd_data), .rd_req(rd_req), .wr_data(wr_data),
        .wr_valid(wr_valid), .busy(busy)
    );

    always @(negedge clk) begin
        if (wr_valid) wv_log.push_back(wr_data);
        if (rd_req) rdreq_cnt++;
        if (rd_req && wr_valid) both_cnt++;
        if (m_sda && !sda_bus) slave_low_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic wbit(input logic b);
        m_sda = b; tick(Q); scl = 1'b1; tick(2 * Q); scl = 1'b0; tick(Q);
    endtask

    task automatic rbit(output logic b);
        m_sda = 1'b1; tick(Q); scl = 1'b1; tick(Q); #1 b = sda_bus; tick(Q); scl = 1'b0; tick(Q);
    endtask

    task automatic m_start();
        m_sda = 1'b1; tick(Q); scl = 1'b1; tick(Q); m_sda = 1'b0; tick(Q); scl = 1'b0; tick(Q);
    endtask

    task automatic m_stop();
        m_sda = 1'b0; tick(Q); scl = 1'b1; tick(Q); m_sda = 1'b1; tick(Q);
    endtask

    task automatic wbyte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) wbit(b[i]);
        rbit(ack);
    endtask

    task automatic rbits8(output logic [7:0] b);
        logic x;
        for (int i = 7; i >= 0; i--) begin
            rbit(x);
            b[i] = x;
        end
    endtask

    function automatic vec_t model(input logic [6:0] a, input logic rw, input int n, input logic [31:0] d);
        vec_t v;
        logic hit;
        hit = (a == 7'h42);
        v.addr = a; v.rw = rw; v.n = n; v.data = d;
        v.exp_aack = !hit;
        v.exp_busy = hit && !rw;
        v.exp_cnt = hit ? n : 0;
        v.exp_bytes = (rw && !hit) ? 32'hFFFF_FFFF : d;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        int wv0, rq0, low0;
        logic aack, a;
        logic [7:0] b;
        wv0 = wv_log.size(); rq0 = rdreq_cnt; low0 = slave_low_cnt;
        if (v.rw) rd_data = v.data[31:24];
        m_start();
        wbyte({v.addr, v.rw}, aack);
        check("addr_ack", aack, v.exp_aack);
        for (int i = 0; i < v.n; i++) begin
            if (v.rw) begin
                rbits8(b);
                check("rd_byte", b, v.exp_bytes[24 - 8 * i +: 8]);
                if (i < v.n - 1) rd_data = v.data[16 - 8 * i +: 8];
                wbit(i == v.n - 1);
            end else begin
                wbyte(v.data[24 - 8 * i +: 8], a);
                check("data_ack", a, v.exp_aack);
            end
        end
        #1 check("busy_pre_stop", busy, v.exp_busy);
        m_stop();
        #1 check("busy_post_stop", busy, 1'b0);
        check("event_count", v.rw ? rdreq_cnt - rq0 : wv_log.size() - wv0, v.exp_cnt);
        if (!v.rw)
            for (int i = 0; i < wv_log.size() - wv0; i++)
                check("wr_byte", wv_log[wv0 + i], v.exp_bytes[24 - 8 * i +: 8]);
        if (v.exp_aack) check("no_drive", slave_low_cnt - low0, 0);
    endtask

    initial begin
        vec_t tbl[4];
        vec_t rv;
        logic a;
        logic [7:0] b;
        int wv0;
        tbl[0] = '{7'h42, 1'b0, 2, 32'hA53C_0000, 1'b0, 1'b1, 2, 32'hA53C_0000};
        tbl[1] = '{7'h42, 1'b1, 2, 32'h960F_0000, 1'b0, 1'b0, 2, 32'h960F_0000};
        tbl[2] = '{7'h43, 1'b0, 2, 32'hA53C_0000, 1'b1, 1'b0, 0, 32'hA53C_0000};
        tbl[3] = '{7'h10, 1'b1, 2, 32'h1234_0000, 1'b1, 1'b0, 0, 32'hFFFF_0000};

        tick(3);
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_wr_valid", wr_valid, 1'b0);
        check("rst_rd_req", rd_req, 1'b0);
        check("rst_wr_data", wr_data, 8'h00);
        check("rst_sda", sda_bus, 1'b1);
        rst = 1'b0;
        tick(4);

        for (int i = 0; i < 4; i++) run_vec(tbl[i]);

        for (int i = 0; i < 10; i++) begin
            rv = model(($urandom_range(0, 3) != 0) ? 7'h42 : 7'($urandom_range(0, 127)),
                       1'($urandom_range(0, 1)), $urandom_range(1, 3), $urandom);
            run_vec(rv);
        end

        // write then repeated START into a read
        wv0 = wv_log.size();
        rd_data = 8'hC3;
        m_start();
        wbyte(8'h84, a); check("rs_addr_w_ack", a, 1'b0);
        wbyte(8'h11, a); check("rs_data_ack", a, 1'b0);
        check("rs_wv_count", wv_log.size() - wv0, 1);
        if (wv_log.size() > wv0) check("rs_wr_byte", wv_log[wv0], 8'h11);
        m_start();
        #1 check("rs_busy_after_restart", busy, 1'b0);
        wbyte(8'h85, a); check("rs_addr_r_ack", a, 1'b0);
        rbits8(b); check("rs_rd_byte", b, 8'hC3);
        wbit(1'b1);
        m_stop();

        // reset in the middle of a read byte
        rd_data = 8'h80;
        m_start();
        wbyte(8'h85, a); check("mr_addr_ack", a, 1'b0);
        for (int i = 2; i >= 0; i--) begin
            rbit(a);
            b[i] = a;
        end
        check("mr_first_bits", b[2:0], 3'b100);
        #1 check("mr_driving_bit4", sda_bus, 1'b0);
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        check("mr_sda_released", sda_bus, 1'b1);
        check("mr_busy", busy, 1'b0);
        check("mr_wr_data", wr_data, 8'h00);
        check("mr_wr_valid", wr_valid, 1'b0);
        check("mr_rd_req", rd_req, 1'b0);
        rst = 1'b0;
        tick(Q); scl = 1'b1; tick(Q);
        wv0 = wv_log.size();
        m_start();
        wbyte(8'h84, a); check("mr_next_addr_ack", a, 1'b0);
        wbyte(8'h5A, a); check("mr_next_data_ack", a, 1'b0);
        m_stop();
        check("mr_next_wv_count", wv_log.size() - wv0, 1);
        if (wv_log.size() > wv0) check("mr_next_wr_byte", wv_log[wv0], 8'h5A);

        // STOP in the middle of a write byte
        m_start();
        wbyte(8'h84, a); check("ms_addr_ack", a, 1'b0);
        wv0 = wv_log.size();
        for (int i = 0; i < 4; i++) wbit(1'(i));
        m_stop();
        #1 check("ms_busy", busy, 1'b0);
        check("ms_sda", sda_bus, 1'b1);
        tick(2 * Q);
        check("ms_no_wv", wv_log.size() - wv0, 0);

        check("pulse_overlap", both_cnt, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
